powlib_grayptrsync: RTL and testbench

Single-clock pointer stage for a gray-coded clock-domain-crossing FIFO. It holds one side's binary pointer and publishes that pointer gray-encoded from a register. It takes the other side's gray pointer through an S-stage flop synchroniser, decodes it, and derives occupancy plus the blocking flag: full on the write side, empty on the read side. One instance sits in each domain, directly downstream of the peer's gray encode register.

---
 rtl/powlib_grayptrsync.sv | 56 +++++
 tb/tb_powlib_grayptrsync.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/powlib_grayptrsync.sv
// powlib_grayptrsync: one side's pointer stage of a gray-coded CDC FIFO
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   adv, acc   advance request in, accepted-this-cycle out (adv & ~flag)
//   ptr, gptr  local binary pointer and its registered gray copy for the peer
//   rgptr      peer gray pointer (asynchronous), rptr its synchronised binary decode
//   cnt, flag  occupancy mod 2^W, full (ISWR=1) or empty (ISWR=0)
module powlib_grayptrsync #(
    parameter int W    = 4,
    parameter int S    = 2,
    parameter bit ISWR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic         acc,
    output logic [W-1:0] ptr,
    output logic [W-1:0] gptr,
    input  logic [W-1:0] rgptr,
    output logic [W-1:0] rptr,
    output logic [W-1:0] cnt,
    output logic         flag
);
    localparam logic [W-1:0] D = {1'b1, {(W-1){1'b0}}};

    logic [S-1:0][W-1:0] sync;
    logic [W-1:0]        ptr_next;

    function automatic logic [W-1:0] gray_dec(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // the remote view lags, so flags only ever err towards blocking
    assign cnt      = ISWR ? ptr - rptr : rptr - ptr;
    assign flag     = ISWR ? cnt == D : cnt == '0;
    assign acc      = adv & ~flag;
    assign ptr_next = ptr + W'(acc);

    // gptr is encoded from ptr_next so the flop output itself is glitch-free gray
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            gptr <= '0;
            sync <= '0;
            rptr <= '0;
        end else begin
            ptr  <= ptr_next;
            gptr <= ptr_next ^ (ptr_next >> 1);
            sync <= {sync[S-2:0], rgptr};
            rptr <= gray_dec(sync[S-1]);
        end
    end
endmodule

// File: tb/tb_powlib_grayptrsync.sv
// tb_powlib_grayptrsync: directed checks of write- and read-side pointer stages
module tb_powlib_grayptrsync;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       adv_w = 1'b0, adv_r = 1'b0;
    logic [3:0] rgptr_w = '0, rgptr_r = '0;
    logic       acc_w, acc_r, flag_w, flag_r;
    logic [3:0] ptr_w, gptr_w, rptr_w, cnt_w;
    logic [3:0] ptr_r, gptr_r, rptr_r, cnt_r;
    int         vec = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    powlib_grayptrsync #(.W(4), .S(2), .ISWR(1'b1)) u_wr (
        .clk(clk), .rst(rst), .adv(adv_w), .acc(acc_w), .ptr(ptr_w), .gptr(gptr_w),
        .rgptr(rgptr_w), .rptr(rptr_w), .cnt(cnt_w), .flag(flag_w)
    );

    powlib_grayptrsync #(.W(4), .S(2), .ISWR(1'b0)) u_rd (
        .clk(clk), .rst(rst), .adv(adv_r), .acc(acc_r), .ptr(ptr_r), .gptr(gptr_r),
        .rgptr(rgptr_r), .rptr(rptr_r), .cnt(cnt_r), .flag(flag_r)
    );

    function automatic logic [3:0] g(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        adv_w = 0; adv_r = 0; rgptr_w = 0; rgptr_r = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (ptr_w !== 4'd0) begin errs++; $display("FAIL reset_ptr got %h want 0", ptr_w); end
        vec++; if (gptr_w !== 4'd0) begin errs++; $display("FAIL reset_gptr got %h want 0", gptr_w); end
        vec++; if (rptr_w !== 4'd0) begin errs++; $display("FAIL reset_rptr got %h want 0", rptr_w); end
        vec++; if (cnt_w !== 4'd0) begin errs++; $display("FAIL reset_cnt got %h want 0", cnt_w); end
        vec++; if (flag_w !== 1'b0) begin errs++; $display("FAIL reset_flag_wr got %b want 0", flag_w); end
        vec++; if (flag_r !== 1'b1) begin errs++; $display("FAIL reset_flag_rd got %b want 1", flag_r); end
        adv_w = 1; adv_r = 1;
        #1;
        vec++; if (acc_w !== 1'b1) begin errs++; $display("FAIL reset_acc_wr got %b want 1", acc_w); end
        vec++; if (acc_r !== 1'b0) begin errs++; $display("FAIL reset_acc_rd got %b want 0", acc_r); end
        adv_w = 0; adv_r = 0;
        #1;
    endtask

    task automatic test_write_fill();
        adv_w = 1;
        #1;
        for (int k = 1; k <= 10; k++) begin
            vec++; if (acc_w !== (k <= 8)) begin errs++; $display("FAIL fill_acc[%0d] got %b want %b", k, acc_w, k <= 8); end
            tick();
            vec++; if (ptr_w !== 4'((k < 8) ? k : 8)) begin errs++; $display("FAIL fill_ptr[%0d] got %0d want %0d", k, ptr_w, (k < 8) ? k : 8); end
        end
        adv_w = 0;
        vec++; if (flag_w !== 1'b1) begin errs++; $display("FAIL fill_flag got %b want 1", flag_w); end
        vec++; if (gptr_w !== 4'b1100) begin errs++; $display("FAIL fill_gptr got %b want 1100", gptr_w); end
    endtask

    task automatic test_write_release();
        rgptr_w = 4'b0010;
        tick();
        tick();
        vec++; if (flag_w !== 1'b1) begin errs++; $display("FAIL release_early got %b want 1", flag_w); end
        tick();
        vec++; if (rptr_w !== 4'd3) begin errs++; $display("FAIL release_rptr got %0d want 3", rptr_w); end
        vec++; if (cnt_w !== 4'd5) begin errs++; $display("FAIL release_cnt got %0d want 5", cnt_w); end
        vec++; if (flag_w !== 1'b0) begin errs++; $display("FAIL release_flag got %b want 0", flag_w); end
        adv_w = 1;
        tick();
        adv_w = 0;
        vec++; if (cnt_w !== 4'd6) begin errs++; $display("FAIL release_adv_cnt got %0d want 6", cnt_w); end
    endtask

    task automatic test_read_drain();
        do_reset();
        adv_r = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            vec++; if (acc_r !== 1'b0) begin errs++; $display("FAIL drain_empty_acc[%0d] got %b want 0", k, acc_r); end
            tick();
        end
        adv_r = 0;
        vec++; if (ptr_r !== 4'd0) begin errs++; $display("FAIL drain_empty_ptr got %0d want 0", ptr_r); end
        rgptr_r = 4'b0111;
        tick();
        tick();
        vec++; if (flag_r !== 1'b1) begin errs++; $display("FAIL drain_early got %b want 1", flag_r); end
        tick();
        vec++; if (cnt_r !== 4'd5) begin errs++; $display("FAIL drain_cnt got %0d want 5", cnt_r); end
        vec++; if (flag_r !== 1'b0) begin errs++; $display("FAIL drain_flag got %b want 0", flag_r); end
        adv_r = 1;
        #1;
        for (int k = 1; k <= 7; k++) begin
            vec++; if (acc_r !== (k <= 5)) begin errs++; $display("FAIL drain_acc[%0d] got %b want %b", k, acc_r, k <= 5); end
            tick();
        end
        adv_r = 0;
        vec++; if (ptr_r !== 4'd5) begin errs++; $display("FAIL drain_ptr got %0d want 5", ptr_r); end
        vec++; if (flag_r !== 1'b1) begin errs++; $display("FAIL drain_final_flag got %b want 1", flag_r); end
        vec++; if (cnt_r !== 4'd0) begin errs++; $display("FAIL drain_final_cnt got %0d want 0", cnt_r); end
    endtask

    task automatic test_wrap();
        logic [3:0] p, prev;
        do_reset();
        p = 0;
        for (int i = 0; i < 19; i++) begin
            rgptr_w = g(p - 4'd2);
            tick();
            tick();
            tick();
            vec++; if (rptr_w !== 4'(p - 4'd2)) begin errs++; $display("FAIL wrap_rptr[%0d] got %0d want %0d", i, rptr_w, 4'(p - 4'd2)); end
            vec++; if (cnt_w !== 4'd2) begin errs++; $display("FAIL wrap_cnt[%0d] got %0d want 2", i, cnt_w); end
            prev = gptr_w;
            adv_w = 1;
            tick();
            adv_w = 0;
            p = p + 4'd1;
            vec++; if (ptr_w !== p) begin errs++; $display("FAIL wrap_ptr[%0d] got %0d want %0d", i, ptr_w, p); end
            vec++; if (gptr_w !== g(p)) begin errs++; $display("FAIL wrap_gptr[%0d] got %b want %b", i, gptr_w, g(p)); end
            vec++; if ($countones(prev ^ gptr_w) != 1) begin errs++; $display("FAIL wrap_onebit[%0d] got %b->%b want one bit change", i, prev, gptr_w); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        rgptr_w = 4'b0011;
        adv_w = 1;
        for (int k = 0; k < 6; k++) tick();
        adv_w = 0;
        vec++; if (cnt_w !== 4'd4) begin errs++; $display("FAIL simul_pre_cnt got %0d want 4", cnt_w); end
        rgptr_w = 4'b0110;
        tick();
        tick();
        vec++; if (rptr_w !== 4'd2) begin errs++; $display("FAIL simul_pre_rptr got %0d want 2", rptr_w); end
        adv_w = 1;
        tick();
        adv_w = 0;
        vec++; if (ptr_w !== 4'd7) begin errs++; $display("FAIL simul_ptr got %0d want 7", ptr_w); end
        vec++; if (rptr_w !== 4'd4) begin errs++; $display("FAIL simul_rptr got %0d want 4", rptr_w); end
        vec++; if (cnt_w !== 4'd3) begin errs++; $display("FAIL simul_cnt got %0d want 3", cnt_w); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        rgptr_w = 4'b0011;
        adv_w = 1;
        for (int k = 0; k < 5; k++) tick();
        adv_w = 0;
        rgptr_w = 4'b0110;
        tick();
        tick();
        vec++; if (ptr_w !== 4'd5) begin errs++; $display("FAIL mid_pre_ptr got %0d want 5", ptr_w); end
        rgptr_w = 4'b0000;
        rst = 1;
        adv_w = 1;
        tick();
        rst = 0;
        adv_w = 0;
        vec++; if (ptr_w !== 4'd0) begin errs++; $display("FAIL mid_ptr got %0d want 0", ptr_w); end
        vec++; if (gptr_w !== 4'd0) begin errs++; $display("FAIL mid_gptr got %b want 0000", gptr_w); end
        vec++; if (rptr_w !== 4'd0) begin errs++; $display("FAIL mid_rptr got %0d want 0", rptr_w); end
        vec++; if (cnt_w !== 4'd0) begin errs++; $display("FAIL mid_cnt got %0d want 0", cnt_w); end
        vec++; if (flag_w !== 1'b0) begin errs++; $display("FAIL mid_flag_wr got %b want 0", flag_w); end
        vec++; if (flag_r !== 1'b1) begin errs++; $display("FAIL mid_flag_rd got %b want 1", flag_r); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vec++; if (rptr_w !== 4'd0) begin errs++; $display("FAIL mid_inflight[%0d] got %0d want 0", k, rptr_w); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_write_fill();
        test_write_release();
        test_read_drain();
        test_wrap();
        test_simultaneous();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
